gap_pool_mc: RTL

- Multi-channel global average pooling for the EfficientNet head and squeeze-excite paths.
- Consumes a channel-interleaved pixel stream: pixel 0 channels 0..CH-1, then pixel 1, and so on.
- Accumulates one sum per channel over a run-time selected spatial size: 28x28, 14x14 or 7x7.
- Then drains CH averages over a valid/ready output handshake, dividing by reciprocal multiply with saturation.

---
 rtl/gap_pool_pkg.sv | 39 +++
 rtl/gap_pool_div.sv | 33 +++
 rtl/gap_pool_mc.sv | 125 ++++++++++++
 3 files changed

// File: rtl/gap_pool_pkg.sv
// Shared types and constants for the gap_pool_mc global average pooling block.
// Maps the run-time size select onto a pixel count and its reciprocal.
package gap_pool_pkg;

    localparam int PIX_W   = 10;
    localparam int RECIP_W = 11;

    typedef enum logic [1:0] {
        SZ28 = 2'd0,
        SZ14 = 2'd1,
        SZ7  = 2'd2
    } size_t;

    localparam logic [PIX_W-1:0]   N28 = 10'd784;
    localparam logic [PIX_W-1:0]   N14 = 10'd196;
    localparam logic [PIX_W-1:0]   N7  = 10'd49;

    // round(2^16 / N) for each supported spatial size
    localparam logic [RECIP_W-1:0] R28 = 11'd84;
    localparam logic [RECIP_W-1:0] R14 = 11'd334;
    localparam logic [RECIP_W-1:0] R7  = 11'd1337;

    typedef struct packed {
        logic [PIX_W-1:0]   n;
        logic [RECIP_W-1:0] recip;
    } size_cfg_t;

    // Reserved encoding 3 falls back to 7x7.
    function automatic size_cfg_t size_cfg(input logic [1:0] sel);
        size_cfg_t c;
        case (sel)
            SZ28:    begin c.n = N28; c.recip = R28; end
            SZ14:    begin c.n = N14; c.recip = R14; end
            default: begin c.n = N7;  c.recip = R7;  end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gap_pool_div.sv
// Reciprocal-multiply divider: avg = sat((acc * recip [+ half]) >> RECIP_FRAC).
// Rounding (half up) is enabled by defining GAP_POOL_ROUND_EN; default truncates.
module gap_pool_div
    import gap_pool_pkg::*;
#(
    parameter int ACC_W      = 19,
    parameter int DATA_W     = 9,
    parameter int RECIP_FRAC = 16
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [RECIP_W-1:0] recip,
    output logic [DATA_W-1:0]  avg
);

    localparam int PW = ACC_W + 11;

    logic [PW-1:0] prod;
    logic [PW:0]   rsum;
    logic [PW:0]   quo;

    assign prod = PW'(acc) * PW'(recip);

`ifdef GAP_POOL_ROUND_EN
    localparam logic [PW:0] HALF = (PW+1)'(1) << (RECIP_FRAC - 1);
    assign rsum = {1'b0, prod} + HALF;
`else
    assign rsum = {1'b0, prod};
`endif

    assign quo = rsum >> RECIP_FRAC;
    assign avg = (|quo[PW:DATA_W]) ? '1 : quo[DATA_W-1:0];

endmodule

// File: rtl/gap_pool_mc.sv
// Multi-channel global average pooling over a channel-interleaved pixel stream.
// Accumulates CH sums over 28x28/14x14/7x7 pixels, then drains CH averages.
module gap_pool_mc
    import gap_pool_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int CH         = 16,
    parameter int ACC_W      = DATA_W + 10,
    parameter int RECIP_FRAC = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   clr,
    input  logic [1:0]                             size_sel,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_W-1:0]                      in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_W-1:0]                      out_data,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
    output logic                                   out_last
);

    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                     state, state_nxt;
    logic [CH-1:0][ACC_W-1:0]   acc;
    logic [CH_W-1:0]            ch_idx;
    logic [PIX_W-1:0]           pix_cnt;
    size_cfg_t                  cfg;
    logic [CH_W:0]              drain_idx;

    logic                       accept, first_beat, last_beat, out_fire;
    logic                       drain_load, load;
    logic [CH_W-1:0]            sel_ch;
    logic [ACC_W-1:0]           div_acc;
    logic [DATA_W-1:0]          avg;

    assign in_ready   = reset_n && (state == ACCUM);
    assign accept     = in_valid && in_ready && !clr;
    assign first_beat = (pix_cnt == '0) && (ch_idx == '0);
    assign last_beat  = accept && (ch_idx == CH_W'(CH - 1)) && (pix_cnt == cfg.n - 10'd1);
    assign out_fire   = out_valid && out_ready;
    assign drain_load = (state == DRAIN) && (!out_valid || out_ready) && (drain_idx < (CH_W+1)'(CH));
    assign load       = last_beat || drain_load;
    assign sel_ch     = last_beat ? '0 : drain_idx[CH_W-1:0];

    // Channel 0 is loaded on the closing beat itself; with CH=1 that beat is
    // still being summed into the same accumulator, so forward it.
    always_comb begin
        div_acc = acc[sel_ch];
        if (accept && (ch_idx == sel_ch) && (pix_cnt != '0))
            div_acc = acc[sel_ch] + ACC_W'(in_data);
    end

    gap_pool_div #(
        .ACC_W      (ACC_W),
        .DATA_W     (DATA_W),
        .RECIP_FRAC (RECIP_FRAC)
    ) u_div (
        .acc   (div_acc),
        .recip (cfg.recip),
        .avg   (avg)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (out_fire && out_last) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
        if (clr) state_nxt = ACCUM;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ACCUM;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            ch_idx    <= '0;
            pix_cnt   <= '0;
            cfg       <= size_cfg(2'd0);
            drain_idx <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (clr) begin
            ch_idx    <= '0;
            pix_cnt   <= '0;
            drain_idx <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                acc[ch_idx] <= (pix_cnt == '0) ? ACC_W'(in_data) : acc[ch_idx] + ACC_W'(in_data);
                if (first_beat) cfg <= size_cfg(size_sel);
                if (ch_idx == CH_W'(CH - 1)) begin
                    ch_idx  <= '0;
                    pix_cnt <= last_beat ? '0 : pix_cnt + 10'd1;
                end else begin
                    ch_idx  <= ch_idx + 1'b1;
                end
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= avg;
                out_ch    <= sel_ch;
                out_last  <= (sel_ch == CH_W'(CH - 1));
                drain_idx <= {1'b0, sel_ch} + 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
